// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared definitions for the multi-cycle ALU.
//   - opcode encodings (ALU_OP_ADD .. ALU_OP_REMU) and the default opcode width
//   - handshake FSM state encodings (IDLE / BUSY / DONE)
//   - mul/div control decode used by the iterative engine
package alu_mc_pkg;

    localparam int unsigned ALU_OP_W = 5;

    localparam int unsigned ALU_OP_ADD    = 0;
    localparam int unsigned ALU_OP_SUB    = 1;
    localparam int unsigned ALU_OP_AND    = 2;
    localparam int unsigned ALU_OP_OR     = 3;
    localparam int unsigned ALU_OP_XOR    = 4;
    localparam int unsigned ALU_OP_SLL    = 5;
    localparam int unsigned ALU_OP_SRL    = 6;
    localparam int unsigned ALU_OP_SRA    = 7;
    localparam int unsigned ALU_OP_SLT    = 8;
    localparam int unsigned ALU_OP_SLTU   = 9;
    localparam int unsigned ALU_OP_MUL    = 10;
    localparam int unsigned ALU_OP_MULH   = 11;
    localparam int unsigned ALU_OP_MULHSU = 12;
    localparam int unsigned ALU_OP_MULHU  = 13;
    localparam int unsigned ALU_OP_DIV    = 14;
    localparam int unsigned ALU_OP_DIVU   = 15;
    localparam int unsigned ALU_OP_REM    = 16;
    localparam int unsigned ALU_OP_REMU   = 17;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Per-op control for the iterative engine.
    //   is_div : restoring divide instead of shift-add multiply
    //   hi     : mul -> upper half of product; div -> remainder instead of quotient
    //   sgn_a/b: operand is interpreted as two's complement
    typedef struct packed {
        logic is_div;
        logic hi;
        logic sgn_a;
        logic sgn_b;
    } md_ctrl_t;

    function automatic logic is_muldiv(input int unsigned op);
        return (op >= ALU_OP_MUL) && (op <= ALU_OP_REMU);
    endfunction

    function automatic md_ctrl_t md_decode(input int unsigned op);
        md_ctrl_t c;
        c = '0;
        case (op)
            ALU_OP_MULH:   begin c.hi = 1'b1; c.sgn_a = 1'b1; c.sgn_b = 1'b1; end
            ALU_OP_MULHSU: begin c.hi = 1'b1; c.sgn_a = 1'b1; end
            ALU_OP_MULHU:  begin c.hi = 1'b1; end
            ALU_OP_DIV:    begin c.is_div = 1'b1; c.sgn_a = 1'b1; c.sgn_b = 1'b1; end
            ALU_OP_DIVU:   begin c.is_div = 1'b1; end
            ALU_OP_REM:    begin c.is_div = 1'b1; c.hi = 1'b1; c.sgn_a = 1'b1; c.sgn_b = 1'b1; end
            ALU_OP_REMU:   begin c.is_div = 1'b1; c.hi = 1'b1; end
            default:       c = '0;  // MUL: low half is sign-agnostic
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for alu_mc.
//   request : in_valid, in_ready, op, num1, num2
//   response: out_valid, out_ready, result
//   modport slave  - the ALU side
//   modport master - the issuing/consuming side (execute stage or bench)
interface alu_mc_if
    import alu_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = ALU_OP_W
) ();

    logic            in_valid;
    logic            in_ready;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] num1;
    logic [XLEN-1:0] num2;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport slave (
        input  in_valid,
        input  op,
        input  num1,
        input  num2,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );

    modport master (
        output in_valid,
        output op,
        output num1,
        output num2,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

endinterface

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative RV-M engine, one product/quotient bit per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (only pulsed while not busy)
//   op         : opcode (MUL..REMU)
//   a, b       : operands, sampled on start
//   busy       : iterating
//   done       : one-cycle pulse after the last iteration; res valid in that cycle
//   res        : final, sign-corrected result
// Works on magnitudes; sign is applied on the way out. Latency is XLEN
// iterations regardless of operand values.
module alu_muldiv_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = ALU_OP_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int unsigned     CntW    = $clog2(XLEN);
    localparam logic [CntW-1:0] CntLast = CntW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinVal  = {1'b1, {(XLEN-1){1'b0}}};

    md_ctrl_t ctrl, ctrl_q, ctrl_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic neg_q, neg_d;
    logic dz_q, dz_d;
    logic ovf_q, ovf_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;  // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [XLEN-1:0]   opb_q, opb_d;  // multiplicand or divisor magnitude

    logic            neg_a, neg_b;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic            rem_ge;
    logic [XLEN-1:0] rem_nxt;
    logic [2*XLEN-1:0] step_nxt;
    logic [2*XLEN-1:0] prod_full;
    logic [XLEN-1:0]   div_sel;

    assign ctrl = md_decode(32'(op));

    always_comb begin
        neg_a = ctrl.sgn_a & a[XLEN-1];
        neg_b = ctrl.sgn_b & b[XLEN-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
    end

    // One iteration of either algorithm on the shared accumulator.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge   = rem_sh >= {1'b0, opb_q};
        // Kept remainder is always below the divisor, so it fits XLEN bits.
        rem_nxt  = rem_ge ? XLEN'(rem_sh - {1'b0, opb_q}) : rem_sh[XLEN-1:0];
        step_nxt = ctrl_q.is_div ? {rem_nxt, acc_q[XLEN-2:0], rem_ge}
                                 : {mul_sum, acc_q[XLEN-1:1]};
    end

    always_comb begin
        ctrl_d = ctrl_q;
        busy_d = busy_q;
        done_d = 1'b0;
        neg_d  = neg_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        opb_d  = opb_q;
        if (start) begin
            ctrl_d = ctrl;
            busy_d = 1'b1;
            cnt_d  = CntLast;
            acc_d  = {{XLEN{1'b0}}, mag_a};
            opb_d  = mag_b;
            // Remainder takes the dividend's sign; everything else the xor.
            neg_d  = (ctrl.is_div & ctrl.hi) ? neg_a : (neg_a ^ neg_b);
            dz_d   = ctrl.is_div & (b == '0);
            ovf_d  = ctrl.is_div & ctrl.sgn_a & ctrl.sgn_b & (a == MinVal) & (b == '1);
        end else if (busy_q) begin
            acc_d = step_nxt;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divide by zero yields an all-ones quotient magnitude and the dividend as
    // remainder; the remainder path then needs no override, the quotient does.
    always_comb begin
        prod_full = neg_q ? -acc_q : acc_q;
        div_sel   = ctrl_q.hi ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        res       = '0;
        if (ctrl_q.is_div) begin
            res = neg_q ? -div_sel : div_sel;
            if (dz_q && !ctrl_q.hi) begin
                res = '1;
            end
            if (ovf_q) begin
                res = ctrl_q.hi ? '0 : MinVal;
            end
        end else begin
            res = ctrl_q.hi ? prod_full[2*XLEN-1:XLEN] : prod_full[XLEN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            neg_q  <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            opb_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            busy_q <= busy_d;
            done_q <= done_d;
            neg_q  <= neg_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            opb_q  <= opb_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU behind a valid/ready handshake.
//   clk   : core clock
//   rst_n : asynchronous active-low reset
//   bus   : alu_mc_if.slave (in_valid/in_ready/op/num1/num2, out_valid/out_ready/result)
// Single-cycle ops (add/sub/logic/shift/compare) produce out_valid the cycle
// after accept. Mul/div ops run in alu_muldiv_iter and take XLEN+1 cycles.
// Build option: define ALU_MULDIV_EN to include the mul/div engine; without it
// opcodes 10-17 are treated as single-cycle ops returning 0.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned OP_W = ALU_OP_W
) (
    input logic     clk,
    input logic     rst_n,
    alu_mc_if.slave bus
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] alu_res;
    logic [ShW-1:0]  shamt;
    logic            accept;
    logic            is_md;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_res;

`ifdef ALU_MULDIV_EN
    assign is_md = is_muldiv(32'(bus.op));

    alu_muldiv_iter #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept & is_md),
        .op    (bus.op),
        .a     (bus.num1),
        .b     (bus.num2),
        .busy  (md_busy),
        .done  (md_done),
        .res   (md_res)
    );
`else
    assign is_md   = 1'b0;
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
    assign md_res  = '0;
`endif

    // md_busy is redundant with the state check; it keeps a new start off a busy engine.
    assign bus.in_ready  = !md_busy &&
                           ((state_q == StIdle) || ((state_q == StDone) && bus.out_ready));
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;

    assign shamt = bus.num2[ShW-1:0];

    always_comb begin
        alu_res = '0;
        case (32'(bus.op))
            ALU_OP_ADD:  alu_res = bus.num1 + bus.num2;
            ALU_OP_SUB:  alu_res = bus.num1 - bus.num2;
            ALU_OP_AND:  alu_res = bus.num1 & bus.num2;
            ALU_OP_OR:   alu_res = bus.num1 | bus.num2;
            ALU_OP_XOR:  alu_res = bus.num1 ^ bus.num2;
            ALU_OP_SLL:  alu_res = bus.num1 << shamt;
            ALU_OP_SRL:  alu_res = bus.num1 >> shamt;
            ALU_OP_SRA:  alu_res = $unsigned($signed(bus.num1) >>> shamt);
            ALU_OP_SLT:  alu_res = XLEN'($signed(bus.num1) < $signed(bus.num2));
            ALU_OP_SLTU: alu_res = XLEN'(bus.num1 < bus.num2);
            default:     alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    if (is_md) begin
                        state_d = StBusy;
                    end else begin
                        state_d  = StDone;
                        result_d = alu_res;
                    end
                end else if ((state_q == StDone) && bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            StBusy: begin
                if (md_done) begin
                    state_d  = StDone;
                    result_d = md_res;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: self-checking bench for alu_mc (XLEN=32) with a behavioural
// reference model built from plain 64-bit arithmetic.
module tb_alu_mc;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OP_W = 5;

    localparam int unsigned OP_ADD = 0, OP_SUB = 1, OP_SRA = 7, OP_SLT = 8, OP_SLTU = 9;
    localparam int unsigned OP_MUL = 10, OP_MULH = 11, OP_MULHU = 13;
    localparam int unsigned OP_DIV = 14, OP_DIVU = 15, OP_REM = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(XLEN), .OP_W(OP_W)) bus ();

    alu_mc #(.XLEN(XLEN), .OP_W(OP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input int unsigned op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub, d, q;
        logic [63:0] p;
        logic        hi;
        int unsigned sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sh = 32'(b[4:0]);
        p  = '0;
        hi = 1'b0;
`ifndef ALU_MULDIV_EN
        if (op >= 10 && op <= 17) return 32'h0;
`endif
        case (op)
            0:  p = ua + ub;
            1:  p = ua - ub;
            2:  p = {32'b0, a & b};
            3:  p = {32'b0, a | b};
            4:  p = {32'b0, a ^ b};
            5:  p = ua * (longint'(1) << sh);
            6:  p = ua / (longint'(1) << sh);
            7: begin
                d = longint'(1) << sh;
                q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;  // floor, not truncate
                p = q;
            end
            8:  p = (sa < sb) ? 64'd1 : 64'd0;
            9:  p = (ua < ub) ? 64'd1 : 64'd0;
            10: p = ua * ub;
            11: begin p = sa * sb; hi = 1'b1; end
            12: begin p = sa * ub; hi = 1'b1; end
            13: begin p = ua * ub; hi = 1'b1; end
            14: begin
                if (b == 0) p = 64'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
                else p = sa / sb;
            end
            15: p = (b == 0) ? 64'hFFFF_FFFF : ua / ub;
            16: begin
                if (b == 0) p = ua;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 0;
                else p = sa % sb;
            end
            17: p = (b == 0) ? ua : ua % ub;
            default: p = 0;
        endcase
        return hi ? p[63:32] : p[31:0];
    endfunction

    function automatic int ref_latency(input int unsigned op);
`ifdef ALU_MULDIV_EN
        if (op >= 10 && op <= 17) return 33;
`endif
        return 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, wait for its result (pulsing ignored requests while busy), consume it.
    task automatic run_op(input string tag, input int unsigned op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int          lat, cyc, k, bad_rdy;
        logic [31:0] opv;
        exp = ref_result(op, a, b);
        lat = ref_latency(op);
        opv = op;
        bus.out_ready = 1'b0;
        bus.op        = opv[4:0];
        bus.num1      = a;
        bus.num2      = b;
        bus.in_valid  = 1'b1;
        k = 0;
        while (!bus.in_ready && k < 50) begin
            tick();
            k++;
        end
        check({tag, ":in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        cyc = 1;
        bad_rdy = 0;
        while (!bus.out_valid && cyc < 100) begin
            if (bus.in_ready) bad_rdy++;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.op       = 5'($urandom);
            bus.num1     = $urandom;
            bus.num2     = $urandom;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check({tag, ":latency"}, 32'(cyc), 32'(lat));
        check({tag, ":result"}, bus.result, exp);
        if (lat > 1) check({tag, ":busy_in_ready"}, 32'(bad_rdy), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ":drop"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    typedef struct {
        int unsigned op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        vec_t        b2b[4];
        logic [31:0] exp_bp;
        int          cyc;

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.num1      = '0;
        bus.num2      = '0;
        bus.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Reset in the middle of a MUL
        run_op("add10", OP_ADD, 32'd5, 32'd5);
        bus.op       = 5'(OP_MUL);
        bus.num1     = 32'd7;
        bus.num2     = 32'd6;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("midrst_result", bus.result, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        run_op("rst_add", OP_ADD, 32'd1, 32'd2);

        // Back-to-back single-cycle ops, consumer always ready
        b2b[0] = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        b2b[1] = '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        b2b[2] = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        b2b[3] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.op       = 5'(b2b[i].op);
            bus.num1     = b2b[i].a;
            bus.num2     = b2b[i].b;
            bus.in_valid = 1'b1;
            tick();
            check($sformatf("b2b%0d:out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            check($sformatf("b2b%0d:result", i), bus.result, b2b[i].exp);
        end
        bus.in_valid = 1'b0;
        tick();
        check("b2b:drop", {31'b0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b0;

        // Long multiplies
        run_op("mulh_m1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhu_m1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mul3x4", OP_MUL, 32'd3, 32'd4);

        // Division corners
        run_op("divu_by0", OP_DIVU, 32'd7, 32'd0);
        run_op("rem_by0", OP_REM, 32'hFFFF_FFF9, 32'd0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2);

        // Backpressure on a DIVU result, then release together with a pending ADD
        exp_bp        = ref_result(OP_DIVU, 32'd100, 32'd7);
        bus.out_ready = 1'b0;
        bus.op        = 5'(OP_DIVU);
        bus.num1      = 32'd100;
        bus.num2      = 32'd7;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        cyc = 1;
        while (!bus.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("bp:latency", 32'(cyc), 32'(ref_latency(OP_DIVU)));
        bus.op       = 5'(OP_ADD);
        bus.num1     = 32'd20;
        bus.num2     = 32'd22;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d:result", i), bus.result, exp_bp);
            check($sformatf("bp%0d:out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            check($sformatf("bp%0d:in_ready", i), {31'b0, bus.in_ready}, 32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp:release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("bp:add_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("bp:add_result", bus.result, 32'd42);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            run_op($sformatf("rnd%0d", i), $urandom_range(0, 19), pick(), pick());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's combinational ALU.
- Registered single-cycle ops: add/sub/logic/shift/compare.
- Iterative RV-M multiply/divide: shift-add multiply, restoring divide.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline stalls on long ops without external counters.

Parameters:
- XLEN, 32, operand/result width (power of two, >=8).
- OP_W, 5, opcode width.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- op  in  OP_W  operation code.
- num1  in  XLEN  operand A.
- num2  in  XLEN  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- result  out  XLEN  registered result.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (legacy encodings kept).
  - 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU.
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU.
  - Others: result 0, single-cycle class.
- Shift amount: num2[$clog2(XLEN)-1:0]. SLT/SLTU return zero-extended 0/1. Add/sub wrap modulo 2^XLEN.
- FSM states IDLE, BUSY, DONE.
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept = in_valid & in_ready; op, num1, num2 captured on accept.
- Single-cycle class: accept -> DONE next edge; out_valid high 1 cycle after accept.
- Mul/div class: accept -> BUSY.
  - Iteration counter loads XLEN-1, decrements each cycle.
  - One partial-product or quotient bit per cycle.
  - At count 0 -> DONE; out_valid exactly XLEN+1 cycles after accept (33 for XLEN=32).
  - Latency is constant, independent of operand values.
- Signed mul/div:
  - Operate on magnitudes; negate at completion per sign rules.
  - MULHSU treats num1 signed, num2 unsigned.
  - MUL returns low XLEN bits; MULH* return high XLEN bits of the 2*XLEN product.
- Division corner cases (override at completion, latency unchanged):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> num1.
  - Signed overflow (num1=MIN, num2=-1): DIV -> MIN, REM -> 0.
- DONE:
  - result and out_valid held stable until out_ready.
  - out_ready with in_valid in the same cycle: new op accepted back-to-back, no bubble.
  - out_ready without in_valid -> IDLE, out_valid drops next cycle.
- in_valid during BUSY is ignored (in_ready=0); operands are not re-sampled.
- Reset (any state, including mid-iteration):
  - state IDLE, counter 0, result 0, out_valid 0.
  - in_ready 1 after reset deassertion.
  - Partial results discarded.

Optional Feature:
- Macro ALU_MULDIV_EN.
- Defined: opcodes 10-17 behave as above.
- Undefined:
  - Mul/div datapath and BUSY iteration logic not compiled.
  - Opcodes 10-17 take the single-cycle path with result 0.
  - Counter still present but unused (tie off).

Decomposition:
- Shared include alu_defs.vh holds opcode localparams (ALU_OP_ADD..ALU_OP_REMU), FSM state encodings, and OP_W.
- Sub-module alu_muldiv_iter holds the iterative shift-add/restoring engine:
  - Ports: start, op, a, b, busy, done, res.
  - alu_mc owns the handshake FSM and the single-cycle datapath.

Test Plan:
- Reset mid-MUL:
  - Stimulus: accept MUL 7*6, assert rst_n=0 at cycle 10.
  - Required: out_valid=0, result=0; after release in_ready=1; a new ADD 1+2 returns 3 one cycle after accept.
- Single-cycle ops with out_ready=1 every cycle, back-to-back:
  - SUB 0-1 -> 0xFFFFFFFF; SRA 0x80000000>>4 -> 0xF8000000; SLT -1<1 -> 1; SLTU -1<1 -> 0.
  - One result per cycle, no bubbles.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0 and MULHU same operands -> 0xFFFFFFFE:
  - out_valid exactly 33 cycles after accept.
  - in_ready=0 throughout BUSY; in_valid pulses in BUSY are ignored.
- Division corners:
  - DIVU 7/0 -> 0xFFFFFFFF; REM -7/0 -> 0xFFFFFFF9.
  - DIV 0x80000000/-1 -> 0x80000000; REM same -> 0; DIV -7/2 -> -3; REM -7/2 -> -1.
- Backpressure: hold out_ready=0 for 5 cycles after a DIVU 100/7 result.
  - Required: result=14 stable, out_valid=1, in_ready=0.
  - Releasing out_ready together with a pending ADD accepts it the same cycle.
- Build without ALU_MULDIV_EN: MUL 3*4 -> result 0, out_valid 1 cycle after accept.
